// File: rtl/decoder_seq.sv
// Byte-serial handshaked instruction decoder: assembles a 2W-bit instruction, optionally fetches a data byte,
// decodes it and holds the bundle until accepted. Optional counters built only with DECODER_PERF_CNT_EN.
module decoder_seq #(
  parameter int unsigned W     = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [W-1:0]     in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   inst,
  output logic             op_nop,
  output logic             op_load,
  output logic             op_add,
  output logic             op_sub,
  output logic             op_and,
  output logic             op_or,
  output logic             op_xor,
  output logic             op_out_lo,
  output logic             op_out_hi,
  output logic             op_unknown,
  output logic             src_imm,
  output logic             src_ram,
  output logic [2*W-1:0]   rhs,
  output logic [W-1:0]     ram_addr,
  output logic [CNT_W-1:0] cnt_inst,
  output logic [CNT_W-1:0] cnt_unknown
);

  typedef enum logic [1:0] {FETCH_HI, FETCH_LO, FETCH_DATA, HOLD} state_t;

  localparam int unsigned F_NOP    = 9;
  localparam int unsigned F_LOAD   = 8;
  localparam int unsigned F_ADD    = 7;
  localparam int unsigned F_SUB    = 6;
  localparam int unsigned F_AND    = 5;
  localparam int unsigned F_OR     = 4;
  localparam int unsigned F_XOR    = 3;
  localparam int unsigned F_OUT_LO = 2;
  localparam int unsigned F_OUT_HI = 1;
  localparam int unsigned F_UNK    = 0;

  state_t           state_q, state_d;
  logic [W-1:0]     hi_q, hi_d;
  logic [W-1:0]     lo_q, lo_d;
  logic [2*W-1:0]   inst_q, inst_d;
  logic [9:0]       flags_q, flags_d;
  logic             src_imm_q, src_imm_d;
  logic             src_ram_q, src_ram_d;
  logic [2*W-1:0]   rhs_q, rhs_d;
  logic [W-1:0]     ram_addr_q, ram_addr_d;

  logic [2*W-1:0]   dec_inst;
  logic [W-1:0]     dec_h, dec_l;
  logic [3:0]       dec_opc;
  logic [1:0]       dec_src;
  logic             dec_hi, dec_opc_ok, dec_needs_data;
  logic [9:0]       dec_flags;
  logic             dec_imm, dec_ram;
  logic [2*W-1:0]   dec_rhs;
  logic [W-1:0]     dec_addr;

  // Decode runs on the word being completed this cycle; in FETCH_DATA in_data is the operand byte D.
  always_comb begin
    dec_inst   = (state_q == FETCH_DATA) ? {hi_q, lo_q} : {hi_q, in_data};
    dec_h      = dec_inst[2*W-1:W];
    dec_l      = dec_inst[W-1:0];
    dec_opc    = dec_inst[2*W-2 -: 4];
    dec_src    = dec_inst[2*W-6 -: 2];
    dec_hi     = dec_inst[W];
    dec_opc_ok = (dec_opc <= 4'd5);
    dec_flags  = '0;
    dec_imm    = 1'b0;
    dec_ram    = 1'b0;
    dec_rhs    = '0;
    dec_addr   = '0;
    if (!dec_h[W-1]) begin
      if (dec_h == '0)          dec_flags[F_NOP]    = 1'b1;
      else if (dec_h == W'(8))  dec_flags[F_OUT_LO] = 1'b1;
      else if (dec_h == W'(9))  dec_flags[F_OUT_HI] = 1'b1;
      else                      dec_flags[F_UNK]    = 1'b1;
    end else if (!dec_opc_ok || dec_src == 2'b11) begin
      dec_flags[F_UNK] = 1'b1;
    end else begin
      case (dec_opc)
        4'd0:    dec_flags[F_LOAD] = 1'b1;
        4'd1:    dec_flags[F_ADD]  = 1'b1;
        4'd2:    dec_flags[F_SUB]  = 1'b1;
        4'd3:    dec_flags[F_AND]  = 1'b1;
        4'd4:    dec_flags[F_OR]   = 1'b1;
        4'd5:    dec_flags[F_XOR]  = 1'b1;
        default: dec_flags[F_UNK]  = 1'b1;
      endcase
      case (dec_src)
        2'b00: begin
          dec_imm = 1'b1;
          dec_rhs = dec_hi ? {dec_l, {W{1'b0}}} : {{W{1'b0}}, dec_l};
        end
        2'b01: begin
          dec_imm = 1'b1;
          dec_rhs = dec_hi ? {in_data, {W{1'b0}}} : {{W{1'b0}}, in_data};
        end
        2'b10: begin
          dec_ram  = 1'b1;
          dec_addr = dec_l;
        end
        default: ;
      endcase
    end
    dec_needs_data = dec_h[W-1] && dec_opc_ok && (dec_src == 2'b01);
  end

  always_comb begin
    state_d    = state_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    inst_d     = inst_q;
    flags_d    = flags_q;
    src_imm_d  = src_imm_q;
    src_ram_d  = src_ram_q;
    rhs_d      = rhs_q;
    ram_addr_d = ram_addr_q;
    if (flush) begin
      state_d = FETCH_HI;
    end else begin
      case (state_q)
        FETCH_HI: if (in_valid) begin
          hi_d    = in_data;
          state_d = FETCH_LO;
        end
        FETCH_LO: if (in_valid) begin
          lo_d = in_data;
          if (dec_needs_data) begin
            state_d = FETCH_DATA;
          end else begin
            inst_d     = dec_inst;
            flags_d    = dec_flags;
            src_imm_d  = dec_imm;
            src_ram_d  = dec_ram;
            rhs_d      = dec_rhs;
            ram_addr_d = dec_addr;
            state_d    = HOLD;
          end
        end
        FETCH_DATA: if (in_valid) begin
          inst_d     = dec_inst;
          flags_d    = dec_flags;
          src_imm_d  = dec_imm;
          src_ram_d  = dec_ram;
          rhs_d      = dec_rhs;
          ram_addr_d = dec_addr;
          state_d    = HOLD;
        end
        HOLD: if (out_ready) state_d = FETCH_HI;
        default: state_d = FETCH_HI;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FETCH_HI;
      hi_q       <= '0;
      lo_q       <= '0;
      inst_q     <= '0;
      flags_q    <= '0;
      src_imm_q  <= 1'b0;
      src_ram_q  <= 1'b0;
      rhs_q      <= '0;
      ram_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      inst_q     <= inst_d;
      flags_q    <= flags_d;
      src_imm_q  <= src_imm_d;
      src_ram_q  <= src_ram_d;
      rhs_q      <= rhs_d;
      ram_addr_q <= ram_addr_d;
    end
  end

  assign in_ready   = (state_q != HOLD);
  assign out_valid  = (state_q == HOLD);
  assign inst       = inst_q;
  assign op_nop     = flags_q[F_NOP];
  assign op_load    = flags_q[F_LOAD];
  assign op_add     = flags_q[F_ADD];
  assign op_sub     = flags_q[F_SUB];
  assign op_and     = flags_q[F_AND];
  assign op_or      = flags_q[F_OR];
  assign op_xor     = flags_q[F_XOR];
  assign op_out_lo  = flags_q[F_OUT_LO];
  assign op_out_hi  = flags_q[F_OUT_HI];
  assign op_unknown = flags_q[F_UNK];
  assign src_imm    = src_imm_q;
  assign src_ram    = src_ram_q;
  assign rhs        = rhs_q;
  assign ram_addr   = ram_addr_q;

`ifdef DECODER_PERF_CNT_EN
  logic             xfer;
  logic [CNT_W-1:0] cnt_inst_q, cnt_inst_d;
  logic [CNT_W-1:0] cnt_unknown_q, cnt_unknown_d;

  // Counters ignore flush; a handshake coinciding with flush is not a transfer.
  always_comb begin
    xfer          = (state_q == HOLD) && out_ready && !flush;
    cnt_inst_d    = cnt_inst_q;
    cnt_unknown_d = cnt_unknown_q;
    if (xfer && (cnt_inst_q != '1))
      cnt_inst_d = cnt_inst_q + CNT_W'(1);
    if (xfer && flags_q[F_UNK] && (cnt_unknown_q != '1))
      cnt_unknown_d = cnt_unknown_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_inst_q    <= '0;
      cnt_unknown_q <= '0;
    end else begin
      cnt_inst_q    <= cnt_inst_d;
      cnt_unknown_q <= cnt_unknown_d;
    end
  end

  assign cnt_inst    = cnt_inst_q;
  assign cnt_unknown = cnt_unknown_q;
`else
  assign cnt_inst    = '0;
  assign cnt_unknown = '0;
`endif

endmodule

// File: tb/tb_decoder_seq.sv
// Directed, table-driven bench for decoder_seq plus hand sequences for backpressure, flush and reset.
module tb_decoder_seq;
  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [7:0]  in_data, ram_addr;
  logic [15:0] inst, rhs, cnt_inst, cnt_unknown;
  logic        op_nop, op_load, op_add, op_sub, op_and, op_or, op_xor;
  logic        op_out_lo, op_out_hi, op_unknown, src_imm, src_ram;
  logic [9:0]  flags_act;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned m_inst = 0;
  int unsigned m_unk  = 0;

  decoder_seq #(.W(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready), .inst(inst),
    .op_nop(op_nop), .op_load(op_load), .op_add(op_add), .op_sub(op_sub), .op_and(op_and),
    .op_or(op_or), .op_xor(op_xor), .op_out_lo(op_out_lo), .op_out_hi(op_out_hi),
    .op_unknown(op_unknown), .src_imm(src_imm), .src_ram(src_ram), .rhs(rhs),
    .ram_addr(ram_addr), .cnt_inst(cnt_inst), .cnt_unknown(cnt_unknown)
  );

  always #5 clk = ~clk;

  // Flag order: nop load add sub and or xor out_lo out_hi unknown
  assign flags_act = {op_nop, op_load, op_add, op_sub, op_and, op_or, op_xor,
                      op_out_lo, op_out_hi, op_unknown};

  localparam logic [9:0] NOP = 10'b1000000000, LOAD = 10'b0100000000, ADD = 10'b0010000000,
                         SUB = 10'b0001000000, AND = 10'b0000100000, OR  = 10'b0000010000,
                         XOR = 10'b0000001000, OLO = 10'b0000000100, OHI = 10'b0000000010,
                         UNK = 10'b0000000001;

  typedef struct {
    logic [7:0]  b0, b1, b2;
    int unsigned n;
    logic [15:0] inst;
    logic [9:0]  flags;
    logic        imm, ram;
    logic [15:0] rhs;
    logic [7:0]  addr;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] cexp(input int unsigned c);
`ifdef DECODER_PERF_CNT_EN
    return 16'(c);
`else
    return 16'(c - c);
`endif
  endfunction

  task automatic feed(input logic [7:0] b, input string nm);
    in_data  = b;
    in_valid = 1'b1;
    chk({nm, " in_ready"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic check_bundle(input vec_t v, input string nm);
    chk({nm, " out_valid"}, 32'(out_valid), 32'd1);
    chk({nm, " in_ready"},  32'(in_ready),  32'd0);
    chk({nm, " inst"},      32'(inst),      32'(v.inst));
    chk({nm, " flags"},     32'(flags_act), 32'(v.flags));
    chk({nm, " src_imm"},   32'(src_imm),   32'(v.imm));
    chk({nm, " src_ram"},   32'(src_ram),   32'(v.ram));
    chk({nm, " rhs"},       32'(rhs),       32'(v.rhs));
    chk({nm, " ram_addr"},  32'(ram_addr),  32'(v.addr));
  endtask

  // Sends the vector with out_ready high, checks the bundle, then the transfer.
  task automatic run_vec(input vec_t v, input string nm);
    out_ready = 1'b1;
    feed(v.b0, nm);
    feed(v.b1, nm);
    if (v.n == 3) feed(v.b2, nm);
    check_bundle(v, nm);
    @(negedge clk);
    m_inst++;
    if (v.flags == UNK) m_unk++;
    chk({nm, " back to fetch"}, 32'({out_valid, in_ready}), 32'b01);
  endtask

  function automatic vec_t mk(input logic [7:0] b0, b1, b2, input int unsigned n,
                              input logic [15:0] i, input logic [9:0] f, input logic imm, ram,
                              input logic [15:0] r, input logic [7:0] a);
    vec_t v;
    v.b0 = b0; v.b1 = b1; v.b2 = b2; v.n = n; v.inst = i; v.flags = f;
    v.imm = imm; v.ram = ram; v.rhs = r; v.addr = a;
    return v;
  endfunction

  initial begin
    vecs[0]  = mk(8'h88, 8'h34, 8'h00, 2, 16'h8834, ADD,  1, 0, 16'h0034, 8'h00);
    vecs[1]  = mk(8'h83, 8'h00, 8'h5A, 3, 16'h8300, LOAD, 1, 0, 16'h5A00, 8'h00);
    vecs[2]  = mk(8'h84, 8'h20, 8'h00, 2, 16'h8420, LOAD, 0, 1, 16'h0000, 8'h20);
    vecs[3]  = mk(8'h00, 8'h00, 8'h00, 2, 16'h0000, NOP,  0, 0, 16'h0000, 8'h00);
    vecs[4]  = mk(8'h08, 8'h11, 8'h00, 2, 16'h0811, OLO,  0, 0, 16'h0000, 8'h00);
    vecs[5]  = mk(8'h07, 8'h00, 8'h00, 2, 16'h0700, UNK,  0, 0, 16'h0000, 8'h00);
    vecs[6]  = mk(8'h8F, 8'h01, 8'h00, 2, 16'h8F01, UNK,  0, 0, 16'h0000, 8'h00);
    vecs[7]  = mk(8'h89, 8'hFF, 8'h00, 2, 16'h89FF, ADD,  1, 0, 16'hFF00, 8'h00);
    vecs[8]  = mk(8'hA2, 8'h3C, 8'h77, 3, 16'hA23C, OR,   1, 0, 16'h0077, 8'h00);
    vecs[9]  = mk(8'hB0, 8'h55, 8'h00, 2, 16'hB055, UNK,  0, 0, 16'h0000, 8'h00);
    vecs[10] = mk(8'hB2, 8'h01, 8'h00, 2, 16'hB201, UNK,  0, 0, 16'h0000, 8'h00);
    vecs[11] = mk(8'h9C, 8'h40, 8'h00, 2, 16'h9C40, AND,  0, 1, 16'h0000, 8'h40);
    vecs[12] = mk(8'hAB, 8'h12, 8'hC3, 3, 16'hAB12, XOR,  1, 0, 16'hC300, 8'h00);
    vecs[13] = mk(8'h09, 8'h00, 8'h00, 2, 16'h0900, OHI,  0, 0, 16'h0000, 8'h00);
    vecs[14] = mk(8'h80, 8'h00, 8'h00, 2, 16'h8000, LOAD, 1, 0, 16'h0000, 8'h00);
    vecs[15] = mk(8'h81, 8'h7E, 8'h00, 2, 16'h817E, LOAD, 1, 0, 16'h7E00, 8'h00);

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset in_ready",  32'(in_ready),  32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset inst",      32'(inst),      32'd0);
    chk("reset flags",     32'(flags_act), 32'd0);

    for (int i = 0; i < 16; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: bundle held 5 cycles while in_valid is asserted with junk.
    out_ready = 1'b0;
    feed(8'h90, "bp");
    feed(8'h07, "bp");
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_data = 8'hFF;
      check_bundle(mk(8'h90, 8'h07, 8'h00, 2, 16'h9007, SUB, 1, 0, 16'h0007, 8'h00),
                   $sformatf("bp%0d", k));
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("bp still valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    m_inst++;
    chk("bp transferred", 32'({out_valid, in_ready}), 32'b01);
    run_vec(vecs[0], "after bp");

    // Flush after the first byte drops it; the byte offered during flush is not taken.
    feed(8'h88, "fl");
    flush = 1'b1; in_valid = 1'b1; in_data = 8'h34;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("flush out_valid", 32'(out_valid), 32'd0);
    run_vec(mk(8'h09, 8'h00, 8'h00, 2, 16'h0900, OHI, 0, 0, 16'h0000, 8'h00), "fl outhi");

    // Flush while holding: bundle dropped, handshake in same cycle is not a transfer.
    out_ready = 1'b0;
    feed(8'h07, "flh");
    feed(8'h00, "flh");
    chk("flh valid", 32'(out_valid), 32'd1);
    flush = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flh dropped", 32'({out_valid, in_ready}), 32'b01);
    chk("cnt_inst total",    32'(cnt_inst),    32'(cexp(m_inst)));
    chk("cnt_unknown total", 32'(cnt_unknown), 32'(cexp(m_unk)));

    // Reset mid-instruction.
    feed(8'h88, "rst");
    rst = 1'b1;
    #1;
    chk("rst in_ready",  32'(in_ready),  32'd1);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst inst",      32'(inst),      32'd0);
    chk("rst rhs",       32'(rhs),       32'd0);
    chk("rst flags",     32'(flags_act), 32'd0);
    chk("rst cnt_inst",  32'(cnt_inst),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    m_inst = 0; m_unk = 0;
    run_vec(vecs[3], "cnt nop");
    run_vec(vecs[5], "cnt unk0700");
    run_vec(vecs[6], "cnt unk8F01");
    chk("cnt_inst final",    32'(cnt_inst),    32'(cexp(3)));
    chk("cnt_unknown final", 32'(cnt_unknown), 32'(cexp(2)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/decoder_seq.md
# decoder_seq

Byte-serial, handshaked instruction decoder; successor to the combinational single-word decoder. It assembles a 2·W-bit instruction from a W-bit byte stream, fetches an extra operand byte when the instruction's source is "data", decodes it, and holds the decoded bundle until the execute stage accepts it. It sits between the program-byte fetch interface and the ALU/accumulator stage.

## Interface
- W, 8, byte width; instruction width is 2·W, rhs width is 2·W
- CNT_W, 16, width of the optional performance counters
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous discard of the partial instruction and any held output
- in_data  in  W  program byte stream, high byte of the instruction first
- in_valid  in  1  in_data is valid
- in_ready  out  1  decoder accepts in_data this cycle
- out_valid  out  1  decoded bundle is valid
- out_ready  in  1  consumer accepts the bundle
- inst  out  2W  assembled instruction word
- op_nop, op_load, op_add, op_sub, op_and, op_or, op_xor, op_out_lo, op_out_hi, op_unknown  out  1 each  one-hot opcode flags
- src_imm, src_ram  out  1 each  operand source
- rhs  out  2W  right-hand operand
- ram_addr  out  W  RAM operand address
- cnt_inst, cnt_unknown  out  CNT_W each  performance counters

## Operation
- Field map, with H = inst[2W-1:W] and L = inst[W-1:0]. inst[2W-1] = 0 selects zero-arg; inst[2W-1] = 1 selects one-arg.
- Zero-arg: H = 0 gives nop. H = 8 gives out_lo. H = 9 gives out_hi. Any other H gives unknown.
- One-arg fields: opc = inst[2W-2:2W-5], src = inst[2W-6:2W-7], hi = inst[W].
- opc values: 0 load, 1 add, 2 sub, 3 and, 4 or, 5 xor; 6..15 give unknown.
- src = 00 (const): src_imm = 1. rhs = hi ? {L,0} : {0,L}.
- src = 01 (data): one extra byte D is fetched. src_imm = 1. rhs = hi ? {D,0} : {0,D}.
- src = 10 (ram): src_ram = 1, ram_addr = L, rhs = 0.
- src = 11: unknown.
- For zero-arg and unknown instructions, rhs, ram_addr, src_imm and src_ram are all 0.
- Exactly one op_* flag is high whenever out_valid = 1.
- FSM states: FETCH_HI, FETCH_LO, FETCH_DATA, HOLD.
  - FETCH_HI → FETCH_LO on accept. The byte is stored as H.
  - FETCH_LO → FETCH_DATA on accept if the instruction is one-arg with src = 01; otherwise → HOLD.
  - FETCH_DATA → HOLD on accept.
  - HOLD → FETCH_HI when out_valid && out_ready.
- in_ready = 1 in all FETCH_* states and 0 in HOLD. A byte is accepted when in_valid && in_ready.
- out_valid = 1 only in HOLD. All outputs are registered and stay stable while out_valid && !out_ready.
- flush has priority over every handshake. The next state is FETCH_HI, out_valid = 0 and partial bytes are dropped. A transfer in the same cycle as flush does not count.
- The unknown flag is set at decode. An unknown instruction never stalls or fetches a data byte.

## Timing
- Reset: state FETCH_HI, in_ready = 1, out_valid = 0. inst, rhs, ram_addr, all flags and counters are 0.
- Reset mid-instruction discards the partial instruction; there is no recovery.
- Latency: out_valid rises the cycle after the last byte of the instruction is accepted.
- Throughput: minimum 3 cycles per 2-byte instruction and 4 per data-source instruction, including one HOLD cycle with out_ready = 1.
- in_valid gaps stall the FSM in place with no loss of state.
- out_ready is a don't-care outside HOLD.

## Configuration
- DECODER_PERF_CNT_EN defined:
  - cnt_inst increments on each output transfer.
  - cnt_unknown increments on each transfer with op_unknown = 1.
  - Both counters saturate at 2^CNT_W-1, are unaffected by flush and are cleared by rst.
- Undefined: no counter flops are built; cnt_inst = cnt_unknown = 0 constantly. Ports are present in both builds.

## Test plan
- Add, const, low half: bytes 0x88, 0x34, with out_ready = 1. out_valid rises the cycle after 0x34. Expect op_add = 1, src_imm = 1, rhs = 0x0034, inst = 0x8834. Return to FETCH_HI one cycle later.
- Load, data, high half: bytes 0x83, 0x00, then 0x5A. in_ready stays high for the third byte. Expect op_load = 1, rhs = 0x5A00, out_valid the cycle after 0x5A.
- Load, ram: bytes 0x84, 0x20. Expect src_ram = 1, src_imm = 0, ram_addr = 0x20, rhs = 0.
- Backpressure: decode 0x90, 0x07 (sub, const) with out_ready = 0 for 5 cycles. Outputs stay constant (rhs = 0x0007), in_ready = 0, and in_valid is ignored. Transfer occurs on the cycle out_ready rises.
- flush, reset and out_hi:
  - Accept 0x88, then pulse flush. Then send 0x09, 0x00. Expect op_out_hi = 1, rhs = 0.
  - Assert rst after one byte. Expect all outputs 0 and state FETCH_HI.
- Counters (macro defined): transfer 0x00 0x00, 0x07 0x00, 0x8F 0x01. Expect cnt_inst = 3 and cnt_unknown = 2: 0x0700 is an unknown zero-arg, and 0x8F01 has opc = 1 with src = 11, which is unknown. Without the macro, both counters read 0.
